eb_fifo_flex: RTL and testbench
===============================

Name: eb_fifo_flex

Overview:
- Parametrised elastic-buffer FIFO: the next generation of the team's valid/ready FIFO.
- Supports any DEPTH ≥ 2 (not only powers of two), exposes occupancy and programmable almost-full/almost-empty flags, and adds a synchronous flush.
- Sits between a producer (t_*) and a consumer (i_*) on any streaming datapath as a rate-decoupling buffer.
- First-word-fall-through output.

Parameters:
- DWIDTH, 32, payload width in bits.
- DEPTH, 16, number of entries; any integer ≥ 2.
- CWIDTH, $clog2(DEPTH+1), width of occupancy count and thresholds; derived, do not override.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all contents.
- t_data  input  DWIDTH  producer payload.
- t_valid  input  1  producer offers t_data.
- t_ready  output  1  FIFO can accept this cycle.
- i_data  output  DWIDTH  head-of-queue payload.
- i_valid  output  1  i_data is valid.
- i_ready  input  1  consumer accepts i_data.
- af_thresh  input  CWIDTH  almost-full threshold; quasi-static.
- ae_thresh  input  CWIDTH  almost-empty threshold; quasi-static.
- count  output  CWIDTH  current occupancy, 0..DEPTH.
- almost_full  output  1  count ≥ af_thresh.
- almost_empty  output  1  count ≤ ae_thresh.

Behaviour:
- Reset (async assert, sync-released by the system):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - i_valid = 0, t_ready = 1, almost_full = (af_thresh == 0), almost_empty = 1.
  - Storage array is not reset; i_data is don't-care while i_valid = 0.
- Handshakes:
  - push = t_valid & t_ready.
  - pop = i_valid & i_ready.
  - A transfer occurs only on a cycle where both signals are high.
- t_ready = (count != DEPTH) & !flush.
  - Depends only on registered state plus flush; no combinational path from i_ready to t_ready.
  - When full, a same-cycle pop does NOT allow a push; t_ready rises the cycle after the pop.
- i_valid = (count != 0) & !flush.
  - i_data = mem[rd_ptr], combinational read of registered state (FWFT).
- Latency: a word pushed in cycle N is visible on i_data/i_valid in cycle N+1. No same-cycle bypass when empty.
- Pointers:
  - Each pointer advances by 1 on its own handshake.
  - Wrap from DEPTH-1 to 0 by explicit compare, never by natural overflow.
  - Pointer width is $clog2(DEPTH).
- count:
  - push & !pop → +1.
  - pop & !push → −1.
  - Both or neither → unchanged.
  - count never exceeds DEPTH and never goes below 0, by construction of t_ready/i_valid.
- Flags: almost_full and almost_empty are combinational compares on the registered count.
- Flush:
  - While high, t_ready = 0 and i_valid = 0, so no push or pop occurs.
  - At the next edge wr_ptr, rd_ptr and count all become 0.
  - Flush held for multiple cycles keeps the FIFO empty.
  - Flush on the same cycle as t_valid drops the offered word, because no handshake occurred.
- Reset mid-operation: all contents are lost immediately; outputs take their reset values asynchronously.
- Ordering: strict FIFO, no reordering, no duplication, no loss except by flush or reset.
- Threshold edge cases:
  - af_thresh > DEPTH → almost_full never asserts.
  - ae_thresh ≥ DEPTH → almost_empty always asserts.

Decomposition:
- Package eb_pkg:
  - function ptr_next(ptr, depth) implementing the wrap increment.
  - localparam helper for CWIDTH.
  - typedef eb_status_t {count, almost_full, almost_empty} for reuse by future eb_* blocks.
- One natural sub-module, eb_fifo_ptr: a wrap counter parametrised by DEPTH with inc/clr inputs, instantiated for wr_ptr and rd_ptr.
- count, flags and storage remain in eb_fifo_flex.

Test Plan:
- All scenarios use DWIDTH=8 and DEPTH=5.
- Fill/drain: i_ready=0, push 0x10..0x14 → t_ready=0 after 5th push, count=5, almost_full with af_thresh=4 from count=4; then i_ready=1 → outputs 0x10..0x14 in order, count→0, i_valid=0, almost_empty with ae_thresh=1 at count≤1.
- Wrap (non-power-of-two): 12 continuous push/pop pairs with both valid/ready high after a 2-word preload → count stays 2; data in order across pointer wrap 4→0 twice.
- Full plus simultaneous pop: count=5, t_valid=1, i_ready=1 → the cycle pops 1 word and pushes 0, count=4; next cycle push accepted, count=5.
- Empty latency: empty FIFO, push 0xA5 in cycle N → i_valid=0 in N, i_valid=1 with i_data=0xA5 in N+1.
- Flush: count=3, assert flush for 1 cycle with t_valid=1 and i_ready=1 → t_ready=0 and i_valid=0 during flush, no handshake; next cycle count=0, i_valid=0, t_ready=1.
- Async reset mid-stream: count=3, pulse reset_n low between edges → immediately i_valid=0, count=0, t_ready=1; after release, push 0x01 → read back 0x01 only.

Source files
------------

// File: rtl/eb_pkg.sv
// Shared types and helpers for the eb_* elastic-buffer family.
package eb_pkg;

    localparam int EB_MAX_CWIDTH = 16;

    // Occupancy width for a buffer of `depth` entries (0..depth inclusive).
    function automatic int eb_cwidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap increment by explicit compare, so any depth works, not only powers of two.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    typedef struct packed {
        logic [EB_MAX_CWIDTH-1:0] count;
        logic                     almost_full;
        logic                     almost_empty;
    } eb_status_t;

endpackage

// File: rtl/eb_fifo_ptr.sv
// Wrap-around pointer for an eb FIFO: counts 0..DEPTH-1, clear has priority over increment.
module eb_fifo_ptr
    import eb_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = PW'(ptr_next(int'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/eb_fifo_flex.sv
// Valid/ready FWFT FIFO of arbitrary depth with occupancy, programmable
// almost-full/almost-empty flags and a synchronous flush.
module eb_fifo_flex
    import eb_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int CWIDTH = eb_cwidth(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [DWIDTH-1:0] t_data,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DWIDTH-1:0] i_data,
    output logic              i_valid,
    input  logic              i_ready,
    input  logic [CWIDTH-1:0] af_thresh,
    input  logic [CWIDTH-1:0] ae_thresh,
    output logic [CWIDTH-1:0] count,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CWIDTH-1:0] FULL_CNT = CWIDTH'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [CWIDTH-1:0] count_q;
    logic [CWIDTH-1:0] count_d;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    // Ready/valid derive only from registered count plus flush: no i_ready -> t_ready path.
    assign t_ready = (count_q != FULL_CNT) & ~flush;
    assign i_valid = (count_q != '0) & ~flush;
    assign push    = t_valid & t_ready;
    assign pop     = i_valid & i_ready;

    eb_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (push),
        .ptr     (wr_ptr)
    );

    eb_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (pop),
        .ptr     (rd_ptr)
    );

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= t_data;
        end
    end

    assign i_data = mem_q[rd_ptr];

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);

endmodule

// File: tb/tb_eb_fifo_flex.sv
// Directed bench for eb_fifo_flex at DWIDTH=8, DEPTH=5.
module tb_eb_fifo_flex;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic [7:0] t_data;
    logic       t_valid;
    logic       t_ready;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_ready;
    logic [2:0] af_thresh;
    logic [2:0] ae_thresh;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    eb_fifo_flex #(.DWIDTH(8), .DEPTH(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .t_data       (t_data),
        .t_valid      (t_valid),
        .t_ready      (t_ready),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs set after this are applied at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL reset_i_valid got %b want 0", i_valid); end
        n_cmp++; if (t_ready !== 1'b1) begin n_fail++; $display("FAIL reset_t_ready got %b want 1", t_ready); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got %b want 1", almost_empty); end
        $display("reset checked");
    endtask

    task automatic test_fill_drain();
        i_ready = 1'b0;
        t_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            t_data = 8'h10 + 8'(i);
            #1;
            n_cmp++; if (t_ready !== 1'b1) begin n_fail++; $display("FAIL fill_t_ready[%0d] got %b want 1", i, t_ready); end
            n_cmp++; if (count !== 3'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
            n_cmp++; if (almost_full !== (i >= 4)) begin n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, i >= 4); end
            n_cmp++; if (almost_empty !== (i <= 1)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, i <= 1); end
            $display("push %02h", t_data);
            step();
        end
        t_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd5) begin n_fail++; $display("FAIL full_count got %0d want 5", count); end
        n_cmp++; if (t_ready !== 1'b0) begin n_fail++; $display("FAIL full_t_ready got %b want 0", t_ready); end
        n_cmp++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL full_af got %b want 1", almost_full); end
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (i_valid !== 1'b1) begin n_fail++; $display("FAIL drain_i_valid[%0d] got %b want 1", i, i_valid); end
            n_cmp++; if (i_data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %02h want %02h", i, i_data, 8'h10 + 8'(i)); end
            n_cmp++; if (count !== 3'(5 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 5 - i); end
            n_cmp++; if (almost_empty !== ((5 - i) <= 1)) begin n_fail++; $display("FAIL drain_ae[%0d] got %b want %b", i, almost_empty, (5 - i) <= 1); end
            $display("pop %02h", i_data);
            step();
        end
        i_ready = 1'b0;
        #1;
        n_cmp++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL empty_i_valid got %b want 0", i_valid); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_count got %0d want 0", count); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL empty_ae got %b want 1", almost_empty); end
    endtask

    task automatic test_wrap();
        i_ready = 1'b0;
        t_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            t_data = 8'h20 + 8'(i);
            step();
        end
        i_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            t_data = 8'h22 + 8'(k);
            #1;
            n_cmp++; if (i_data !== 8'h20 + 8'(k) || i_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_data[%0d] got %02h/%b want %02h/1", k, i_data, i_valid, 8'h20 + 8'(k)); end
            n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d want 2", k, count); end
            $display("push %02h pop %02h", t_data, i_data);
            step();
        end
        t_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (i_data !== 8'h2C + 8'(k)) begin n_fail++; $display("FAIL wrap_tail[%0d] got %02h want %02h", k, i_data, 8'h2C + 8'(k)); end
            $display("pop %02h", i_data);
            step();
        end
        i_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_end_count got %0d want 0", count); end
    endtask

    task automatic test_full_pop();
        i_ready = 1'b0;
        t_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            t_data = 8'h30 + 8'(i);
            step();
        end
        t_valid = 1'b0;
        af_thresh = 3'd6;
        ae_thresh = 3'd5;
        #1;
        n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_above_depth got %b want 0", almost_full); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL ae_at_depth got %b want 1", almost_empty); end
        af_thresh = 3'd4;
        ae_thresh = 3'd1;
        t_valid = 1'b1;
        t_data  = 8'h35;
        i_ready = 1'b1;
        #1;
        n_cmp++; if (t_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_t_ready got %b want 0", t_ready); end
        n_cmp++; if (i_data !== 8'h30) begin n_fail++; $display("FAIL fullpop_data got %02h want 30", i_data); end
        $display("pop %02h (push blocked)", i_data);
        step();
        i_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count got %0d want 4", count); end
        n_cmp++; if (t_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_t_ready_next got %b want 1", t_ready); end
        $display("push %02h", t_data);
        step();
        t_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd5) begin n_fail++; $display("FAIL fullpop_refill_count got %0d want 5", count); end
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (i_data !== 8'h31 + 8'(i)) begin n_fail++; $display("FAIL fullpop_drain[%0d] got %02h want %02h", i, i_data, 8'h31 + 8'(i)); end
            $display("pop %02h", i_data);
            step();
        end
        i_ready = 1'b0;
    endtask

    task automatic test_empty_latency();
        t_valid = 1'b1;
        t_data  = 8'hA5;
        i_ready = 1'b0;
        #1;
        n_cmp++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL lat_same_cycle got %b want 0", i_valid); end
        $display("push %02h", t_data);
        step();
        t_valid = 1'b0;
        #1;
        n_cmp++; if (i_valid !== 1'b1 || i_data !== 8'hA5) begin n_fail++; $display("FAIL lat_next_cycle got %b/%02h want 1/a5", i_valid, i_data); end
        i_ready = 1'b1;
        $display("pop %02h", i_data);
        step();
        i_ready = 1'b0;
    endtask

    task automatic test_flush();
        t_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t_data = 8'h40 + 8'(i);
            step();
        end
        flush   = 1'b1;
        t_data  = 8'h43;
        i_ready = 1'b1;
        #1;
        n_cmp++; if (t_ready !== 1'b0 || i_valid !== 1'b0) begin n_fail++; $display("FAIL flush_gate got t_ready=%b i_valid=%b want 0/0", t_ready, i_valid); end
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", count); end
        step();
        flush   = 1'b0;
        t_valid = 1'b0;
        i_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || i_valid !== 1'b0 || t_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after got count=%0d i_valid=%b t_ready=%b want 0/0/1", count, i_valid, t_ready); end
        t_valid = 1'b1;
        t_data  = 8'h50;
        step();
        t_valid = 1'b0;
        #1;
        n_cmp++; if (i_data !== 8'h50 || count !== 3'd1) begin n_fail++; $display("FAIL flush_refill got %02h/%0d want 50/1", i_data, count); end
        i_ready = 1'b1;
        $display("pop %02h", i_data);
        step();
        i_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        t_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t_data = 8'h60 + 8'(i);
            step();
        end
        t_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (i_valid !== 1'b0 || count !== 3'd0 || t_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset got i_valid=%b count=%0d t_ready=%b want 0/0/1", i_valid, count, t_ready); end
        #1;
        reset_n = 1'b1;
        step();
        t_valid = 1'b1;
        t_data  = 8'h01;
        step();
        t_valid = 1'b0;
        #1;
        n_cmp++; if (i_valid !== 1'b1 || i_data !== 8'h01 || count !== 3'd1) begin n_fail++; $display("FAIL post_reset got %b/%02h/%0d want 1/01/1", i_valid, i_data, count); end
        i_ready = 1'b1;
        $display("pop %02h", i_data);
        step();
        i_ready = 1'b0;
        #1;
        n_cmp++; if (i_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL post_reset_empty got %b/%0d want 0/0", i_valid, count); end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        t_data    = 8'h00;
        t_valid   = 1'b0;
        i_ready   = 1'b0;
        af_thresh = 3'd4;
        ae_thresh = 3'd1;
        #10;
        test_reset();
        reset_n = 1'b1;
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_empty_latency();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
